// File: rtl/hash_target_check.sv
// Byte-serial hash vs. target difficulty check.
// Emits one below/equal/error verdict per hash frame over valid/ready.
module hash_target_check #(
   parameter int NBYTES = 32,
   parameter int AW     = 5,
   parameter int CW     = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tgt_wr,
   input  logic [AW-1:0] tgt_addr,
   input  logic [7:0]    tgt_data,
   output logic          tgt_busy,
   input  logic          hash_valid,
   output logic          hash_ready,
   input  logic [7:0]    hash_byte,
   input  logic          hash_last,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_below,
   output logic          res_equal,
   output logic          res_err,
   output logic [CW-1:0] hit_cnt
);

   typedef enum logic [1:0] {
      CMP = 2'd0,
      DRN = 2'd1,
      RES = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NBYTES - 1);
   localparam logic [CW-1:0] HIT_MAX  = {CW{1'b1}};

   state_t        state, state_nx;
   logic [AW-1:0] idx, idx_nx;
   logic          decided, decided_nx;
   logic          below, below_nx;
   logic          rb_nx, re_nx, rerr_nx;
   logic [CW-1:0] hit_nx;

   logic [7:0]    tgt [NBYTES];
   logic [7:0]    tgt_byte;
   logic          beat;
   logic          wr_ok;
   logic          at_end;
   logic          byte_lt, byte_gt;
   logic          dec_now, bel_now;
   logic          frame_ok;

   assign tgt_busy = (idx != '0) || (state != CMP);
   assign wr_ok    = tgt_wr && !tgt_busy;
   assign beat     = hash_valid && hash_ready;
   assign at_end   = (idx == LAST_IDX);

   // A write landing on the first beat is forwarded so byte 0 sees it.
   assign tgt_byte = (wr_ok && (tgt_addr == idx)) ? tgt_data : tgt[idx];
   assign byte_lt  = hash_byte < tgt_byte;
   assign byte_gt  = hash_byte > tgt_byte;

   // Next-state, verdict and handshake logic.
   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      decided_nx = decided;
      below_nx   = below;
      rb_nx      = res_below;
      re_nx      = res_equal;
      rerr_nx    = res_err;
      hit_nx     = hit_cnt;
      hash_ready = (state != RES);
      res_valid  = (state == RES);
      dec_now    = decided;
      bel_now    = below;
      frame_ok   = 1'b0;
      unique case (state)
         CMP, DRN: begin
            if (beat) begin
               if (state == CMP && byte_lt) begin
                  dec_now = 1'b1;
                  bel_now = 1'b1;
               end else if (state == CMP && byte_gt) begin
                  dec_now = 1'b1;
                  bel_now = 1'b0;
               end
               decided_nx = dec_now;
               below_nx   = bel_now;
               if (hash_last || at_end) begin
                  frame_ok = hash_last && at_end;
                  state_nx = RES;
                  rerr_nx  = !frame_ok;
                  rb_nx    = frame_ok && dec_now && bel_now;
                  re_nx    = frame_ok && !dec_now;
               end else begin
                  idx_nx   = idx + 1'b1;
                  state_nx = dec_now ? DRN : CMP;
               end
            end
         end
         RES: begin
            if (res_ready) begin
               state_nx   = CMP;
               idx_nx     = '0;
               decided_nx = 1'b0;
               below_nx   = 1'b0;
               rb_nx      = 1'b0;
               re_nx      = 1'b0;
               rerr_nx    = 1'b0;
               if (res_below && hit_cnt != HIT_MAX) begin
                  hit_nx = hit_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nx = CMP;
            idx_nx   = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CMP;
      end else begin
         state <= state_nx;
      end
   end

   // Frame progress, verdict and hit counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         decided   <= 1'b0;
         below     <= 1'b0;
         res_below <= 1'b0;
         res_equal <= 1'b0;
         res_err   <= 1'b0;
         hit_cnt   <= '0;
      end else begin
         idx       <= idx_nx;
         decided   <= decided_nx;
         below     <= below_nx;
         res_below <= rb_nx;
         res_equal <= re_nx;
         res_err   <= rerr_nx;
         hit_cnt   <= hit_nx;
      end
   end

   // Target store; all-ones after reset, frozen while a frame is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBYTES; i++) begin
            tgt[i] <= 8'hFF;
         end
      end else if (wr_ok && (int'(tgt_addr) < NBYTES)) begin
         tgt[tgt_addr] <= tgt_data;
      end
   end

endmodule

// File: tb/tb_hash_target_check.sv
// Scoreboard bench for hash_target_check.
// Random and directed frames judged by a lexicographic reference model.
module tb_hash_target_check;

   localparam int NB = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int HMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tgt_wr;
   logic [AW-1:0] tgt_addr;
   logic [7:0]    tgt_data;
   logic          tgt_busy;
   logic          hash_valid;
   logic          hash_ready;
   logic [7:0]    hash_byte;
   logic          hash_last;
   logic          res_valid;
   logic          res_ready;
   logic          res_below;
   logic          res_equal;
   logic          res_err;
   logic [CW-1:0] hit_cnt;

   hash_target_check #(.NBYTES(NB), .AW(AW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .tgt_wr(tgt_wr), .tgt_addr(tgt_addr), .tgt_data(tgt_data),
      .tgt_busy(tgt_busy),
      .hash_valid(hash_valid), .hash_ready(hash_ready),
      .hash_byte(hash_byte), .hash_last(hash_last),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_below(res_below), .res_equal(res_equal), .res_err(res_err),
      .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] mtgt [NB];
   logic [7:0] cur [$];
   logic [2:0] sb [$];
   int         mhit = 0;
   int         rdy_mode = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a frame closes on hash_last or on its NB-th byte.
   task automatic model_beat(logic [7:0] b, logic last, output logic ended);
      logic bel, eq, err;
      ended = 1'b0;
      cur.push_back(b);
      if (last || cur.size() == NB) begin
         err = !(last && cur.size() == NB);
         bel = 1'b0;
         eq  = 1'b0;
         if (!err) begin
            eq = 1'b1;
            for (int i = 0; i < NB; i++) begin
               if (eq && cur[i] != mtgt[i]) begin
                  eq  = 1'b0;
                  bel = cur[i] < mtgt[i];
               end
            end
         end
         sb.push_back({bel, eq, err});
         cur.delete();
         ended = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) mtgt[i] = 8'hFF;
      cur.delete();
      sb.delete();
      mhit = 0;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic send(logic [7:0] b, logic last);
      int n;
      logic ended;
      hash_valid = 1'b1;
      hash_byte  = b;
      hash_last  = last;
      n = 0;
      while (!hash_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!hash_ready) chk("beat_timeout", 32'd1, 32'd0);
      @(posedge clk);
      model_beat(b, last, ended);
      @(negedge clk);
      hash_valid = 1'b0;
      hash_last  = 1'b0;
      if (ended) chk("res_latency", 32'(res_valid), 32'd1);
   endtask

   task automatic wr(int a, logic [7:0] d);
      tgt_wr   = 1'b1;
      tgt_addr = AW'(a);
      tgt_data = d;
      @(posedge clk);
      if (!(cur.size() > 0 || sb.size() > 0)) mtgt[a] = d;
      @(negedge clk);
      tgt_wr = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() > 0 || cur.size() > 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("idle_timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame(logic [7:0] f [NB]);
      for (int i = 0; i < NB; i++) send(f[i], i == NB - 1);
   endtask

   // Result-side ready: random, forced low, or forced high.
   always begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         1: res_ready = 1'b0;
         2: res_ready = 1'b1;
         default: res_ready = ($urandom_range(0, 9) < 7);
      endcase
   end

   // Monitor: pops the scoreboard on every accepted verdict.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("hit_cnt", 32'(hit_cnt), 32'(mhit));
         if (res_valid) chk("ready_low_in_res", 32'(hash_ready), 32'd0);
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               logic [2:0] e;
               e = sb.pop_front();
               chk("verdict", {29'd0, res_below, res_equal, res_err},
                   {29'd0, e});
               if (e[2] && mhit != HMAX) mhit++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] f [NB];
      rst_n      = 1'b0;
      tgt_wr     = 1'b0;
      tgt_addr   = '0;
      tgt_data   = '0;
      hash_valid = 1'b0;
      hash_byte  = '0;
      hash_last  = 1'b0;
      res_ready  = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_hash_ready", 32'(hash_ready), 32'd1);
      chk("rst_busy", 32'(tgt_busy), 32'd0);
      chk("rst_res", {29'd0, res_below, res_equal, res_err}, 32'd0);
      chk("rst_hit", 32'(hit_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: below on byte 2
      wr(0, 8'h00);
      wr(1, 8'h00);
      f[0] = 8'h00;
      f[1] = 8'h00;
      f[2] = 8'h10;
      for (int i = 3; i < NB; i++) f[i] = 8'($urandom);
      send_frame(f);
      wait_idle();
      chk("t1_hit", 32'(hit_cnt), 32'd1);

      // 2: equal
      for (int i = 0; i < NB; i++) wr(i, 8'hA5);
      for (int i = 0; i < NB; i++) f[i] = 8'hA5;
      send_frame(f);
      wait_idle();
      chk("t2_hit", 32'(hit_cnt), 32'd1);

      // 3: above decided at byte 0
      wr(0, 8'h10);
      f[0] = 8'h11;
      for (int i = 1; i < NB; i++) f[i] = 8'($urandom);
      send_frame(f);
      wait_idle();

      // 4: short frame with result held back
      rdy_mode = 1;
      for (int i = 0; i < 6; i++) send(8'($urandom), i == 5);
      for (int k = 0; k < 10; k++) begin
         chk("t4_hold_valid", 32'(res_valid), 32'd1);
         chk("t4_hold_err", {29'd0, res_below, res_equal, res_err}, 32'd1);
         chk("t4_hold_ready", 32'(hash_ready), 32'd0);
         @(negedge clk);
      end
      rdy_mode = 0;
      wait_idle();

      // 5: write during frame is dropped, same write when idle lands
      for (int i = 0; i < NB; i++) f[i] = mtgt[i];
      f[3] = 8'h50;
      for (int i = 0; i < 3; i++) send(f[i], 1'b0);
      chk("t5_busy", 32'(tgt_busy), 32'd1);
      wr(3, 8'h00);
      for (int i = 3; i < NB; i++) send(f[i], i == NB - 1);
      wait_idle();
      chk("t5_idle", 32'(tgt_busy), 32'd0);
      wr(3, 8'h00);
      send_frame(f);
      wait_idle();

      // 6: reset mid-frame
      for (int i = 0; i < 12; i++) send(8'($urandom), 1'b0);
      hash_valid = 1'b1;
      hash_byte  = 8'h3C;
      rst_n      = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      hash_valid = 1'b0;
      chk("t6_no_valid", 32'(res_valid), 32'd0);
      chk("t6_busy", 32'(tgt_busy), 32'd0);
      chk("t6_hit", 32'(hit_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      f[0] = 8'hFE;
      for (int i = 1; i < NB; i++) f[i] = 8'($urandom);
      send_frame(f);
      wait_idle();

      // Random frames: near-target hashes, short and overlong frames
      for (int n = 0; n < 90; n++) begin
         int kind, p;
         if (n % 15 == 14) begin
            wait_idle();
            wr($urandom_range(0, NB - 1), 8'($urandom_range(1, 255)));
         end
         if (n == 60) rdy_mode = 2;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            p = $urandom_range(1, NB - 1);
            for (int i = 0; i < p; i++) send(8'($urandom), i == p - 1);
         end else if (kind == 1) begin
            for (int i = 0; i < NB; i++) send(8'($urandom), 1'b0);
         end else begin
            for (int i = 0; i < NB; i++) f[i] = mtgt[i];
            p = $urandom_range(0, NB - 1);
            case ($urandom_range(0, 2))
               0: if (f[p] != 8'h00) f[p] = f[p] - 8'($urandom_range(1, f[p]));
               1: if (f[p] != 8'hFF) f[p] = f[p] + 8'd1;
               default: ;
            endcase
            for (int i = p + 1; i < NB; i++) f[i] = 8'($urandom);
            send_frame(f);
         end
      end
      wait_idle();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
